// File: rtl/alu_operand_regs.sv
// Operand register stage feeding the 8-bit ALU: accumulator A, operand B, readiness tracking.
// Optional zero flag on accumulator writes is enabled by defining OPERAND_REGS_ZERO_FLAG_EN.
module alu_operand_regs #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] A_RESET = '0,
   parameter logic [WIDTH-1:0] B_RESET = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             load_a,
   input  logic             load_b,
   input  logic             acc_write,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             a_out_en,
   input  logic             consume,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic [WIDTH-1:0] bus_out,
   output logic             operands_valid,
   output logic             load_conflict
`ifdef OPERAND_REGS_ZERO_FLAG_EN
   ,
   output logic             zero_flag
`endif
);

   typedef enum logic [1:0] {StEmpty, StHaveA, StHaveB, StFull} state_e;

   state_e           r_state;
   state_e           w_state_next;
   state_e           w_base;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_conflict;
   logic             w_conflict;
   logic             w_a_event;
   logic             w_b_event;

   assign w_conflict = load_a & acc_write;
   assign w_a_event  = load_a ^ acc_write;
   assign w_b_event  = load_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a        <= A_RESET;
         r_b        <= B_RESET;
         r_conflict <= 1'b0;
         r_state    <= StEmpty;
      end else begin
         if (load_a && !acc_write) begin
            r_a <= bus_in;
         end else if (acc_write && !load_a) begin
            r_a <= alu_result;
         end
         if (load_b) begin
            r_b <= bus_in;
         end
         r_conflict <= w_conflict;
         r_state    <= w_state_next;
      end
   end

   // A consumed pair restarts from EMPTY, so same-cycle events are applied to that base.
   always_comb begin
      w_base       = r_state;
      w_state_next = r_state;
      if (r_state == StFull && consume) begin
         w_base = StEmpty;
      end
      unique case (w_base)
         StEmpty: begin
            if (w_a_event && w_b_event) begin
               w_state_next = StFull;
            end else if (w_a_event) begin
               w_state_next = StHaveA;
            end else if (w_b_event) begin
               w_state_next = StHaveB;
            end else begin
               w_state_next = StEmpty;
            end
         end
         StHaveA: w_state_next = w_b_event ? StFull : StHaveA;
         StHaveB: w_state_next = w_a_event ? StFull : StHaveB;
         StFull:  w_state_next = StFull;
         default: w_state_next = StEmpty;
      endcase
   end

`ifdef OPERAND_REGS_ZERO_FLAG_EN
   logic r_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero <= 1'b0;
      end else if (acc_write && !load_a) begin
         r_zero <= (alu_result == '0);
      end
   end

   assign zero_flag = r_zero;
`endif

   assign a_q            = r_a;
   assign b_q            = r_b;
   assign bus_out        = a_out_en ? r_a : '0;
   assign operands_valid = (r_state == StFull);
   assign load_conflict  = r_conflict;

endmodule
